// File: rtl/mem_wb_sequencer_pkg.sv
// rtl/mem_wb_sequencer_pkg.sv - shared widths and FSM state encoding for the MEM/WB sequencer
package mem_wb_sequencer_pkg;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_REG_ADDR_W     = 5;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_WB       = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mem_wb_sequencer_watchdog.sv
// rtl/mem_wb_sequencer_watchdog.sv - MEM_WAIT cycle counter and timeout compare (built only with MEM_TIMEOUT_EN)
`ifdef MEM_TIMEOUT_EN
module mem_wb_sequencer_watchdog
    import mem_wb_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_wait_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    // Outside MEM_WAIT the count sits at zero, so every entry starts fresh.
    always_comb begin
        count_d = count_q;
        if (!in_wait_i) begin
            count_d = '0;
        end else if (!ack_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the last allowed MEM_WAIT cycle; a same-cycle ack takes precedence upstream.
    assign expire_o = in_wait_i && (count_q == LAST);

endmodule
`endif

// File: rtl/mem_wb_sequencer.sv
// rtl/mem_wb_sequencer.sv - MIPS MEM/WB controller: req/ack data-memory sequencing and regfile writeback
// Optional access timeout with mem_err pulse when MEM_TIMEOUT_EN is defined.
module mem_wb_sequencer
    import mem_wb_sequencer_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0]     ex_alu_res,
    input  logic [DATA_W-1:0]     ex_store_data,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  memtoreg_ctrl,
    output logic [DATA_W-1:0]     wb_alu_res,
    output logic [DATA_W-1:0]     wb_mem_data,
    output logic                  mem_err
);

    seq_state_e            state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  wb_en_q, wb_en_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic                  memtoreg_q, memtoreg_d;
    logic [DATA_W-1:0]     wb_alu_res_q, wb_alu_res_d;
    logic [DATA_W-1:0]     wb_mem_data_q, wb_mem_data_d;
    logic                  mem_err_q, mem_err_d;
    logic                  timeout_hit;

`ifdef MEM_TIMEOUT_EN
    mem_wb_sequencer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_wait_i(state_q == ST_MEM_WAIT),
        .ack_i    (dmem_ack),
        .expire_o (timeout_hit)
    );
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        reg_write_d   = reg_write_q;
        wb_en_d       = 1'b0;
        wb_addr_d     = wb_addr_q;
        memtoreg_d    = memtoreg_q;
        wb_alu_res_d  = wb_alu_res_q;
        wb_mem_data_d = wb_mem_data_q;
        mem_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_read || ex_mem_write) begin
                        state_d     = ST_MEM_WAIT;
                        req_d       = 1'b1;
                        we_d        = ~ex_mem_read;
                        addr_d      = ex_alu_res;
                        wdata_d     = ex_store_data;
                        rd_d        = ex_rd;
                        reg_write_d = ex_reg_write;
                    end else if (ex_reg_write && (ex_rd != '0)) begin
                        // wb_* only move on a real writeback so they hold otherwise.
                        wb_en_d      = 1'b1;
                        wb_addr_d    = ex_rd;
                        memtoreg_d   = 1'b0;
                        wb_alu_res_d = ex_alu_res;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (!we_q) begin
                        state_d = ST_WB;
                        if (reg_write_q && (rd_q != '0)) begin
                            wb_en_d       = 1'b1;
                            wb_addr_d     = rd_q;
                            memtoreg_d    = 1'b1;
                            wb_mem_data_d = dmem_rdata;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            wb_en_q       <= 1'b0;
            wb_addr_q     <= '0;
            memtoreg_q    <= 1'b0;
            wb_alu_res_q  <= '0;
            wb_mem_data_q <= '0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
            wb_en_q       <= wb_en_d;
            wb_addr_q     <= wb_addr_d;
            memtoreg_q    <= memtoreg_d;
            wb_alu_res_q  <= wb_alu_res_d;
            wb_mem_data_q <= wb_mem_data_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign stall         = (state_q != ST_IDLE);
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign wb_en         = wb_en_q;
    assign wb_addr       = wb_addr_q;
    assign memtoreg_ctrl = memtoreg_q;
    assign wb_alu_res    = wb_alu_res_q;
    assign wb_mem_data   = wb_mem_data_q;
    assign mem_err       = mem_err_q;

endmodule
